// File: rtl/jpeg_mcu_scheduler.sv
// rtl/jpeg_mcu_scheduler.sv - MCU/block sequencer for a baseline JPEG scan decoder
//
// Walks the block order of every MCU in a scan and gates the bitstream reader.
// Parameters:
//   NUM_COMP  colour components per scan (1 = grayscale, 3 = Y/Cb/Cr)
//   DIM_W     width of img_width / img_height
//   MCU_W     width of the MCU column/row counters
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start_scan                SOS-done pulse; latches geometry in IDLE
//   img_width, img_height     pixel dimensions
//   subsample_mode            00 4:4:4, 01 4:2:2, 10 4:2:0, 11 treated as 4:4:4
//   restart_interval          MCUs between RST markers, 0 disables
//   huff_enable, entropy_reading  bit demand from the entropy path
//   blk_valid                 accumulator holds a complete 8x8 block
//   blk_consumed              serializer finished the current block
//   restart_ack               RSTn marker consumed
//   abort                     synchronous scan cancel
//   bit_ready                 bitstream-reader shift enable (DECODE only)
//   comp_id, blk_in_comp      current component / block within component
//   mcu_x, mcu_y              current MCU column / row
//   dc_pred_reset, restart_req, scan_done   one-cycle pulses
//   busy                      high whenever not IDLE
module jpeg_mcu_scheduler #(
    parameter int NUM_COMP = 3,
    parameter int DIM_W    = 16,
    parameter int MCU_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_scan,
    input  logic [DIM_W-1:0] img_width,
    input  logic [DIM_W-1:0] img_height,
    input  logic [1:0]       subsample_mode,
    input  logic [15:0]      restart_interval,
    input  logic             huff_enable,
    input  logic             entropy_reading,
    input  logic             blk_valid,
    input  logic             blk_consumed,
    input  logic             restart_ack,
    input  logic             abort,
    output logic             bit_ready,
    output logic [1:0]       comp_id,
    output logic [1:0]       blk_in_comp,
    output logic [MCU_W-1:0] mcu_x,
    output logic [MCU_W-1:0] mcu_y,
    output logic             dc_pred_reset,
    output logic             restart_req,
    output logic             scan_done,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_PROCESS,
        S_RESTART,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [1:0]       mode_q;
    logic [MCU_W-1:0] mcus_x_q, mcus_y_q;
    logic [15:0]      ri_q;
    logic [15:0]      rst_cnt;

    logic             dc_pred_reset_n, restart_req_n;

    // Geometry decode of the inputs, latched on an accepted start_scan.
    logic [1:0]       mode_in;
    logic [DIM_W:0]   w_round, h_round;
    logic [MCU_W-1:0] mcus_x_in, mcus_y_in;

    always_comb begin
        mode_in = (NUM_COMP == 1 || subsample_mode == 2'b11) ? 2'b00 : subsample_mode;
        // Round up by adding mcu_size-1 before the shift; the extra MSB keeps the carry.
        w_round = {1'b0, img_width}  + ((mode_in == 2'b00) ? (DIM_W+1)'(7) : (DIM_W+1)'(15));
        h_round = {1'b0, img_height} + ((mode_in == 2'b10) ? (DIM_W+1)'(15) : (DIM_W+1)'(7));
        if (img_width == '0)
            mcus_x_in = MCU_W'(1);
        else if (mode_in == 2'b00)
            mcus_x_in = MCU_W'(w_round >> 3);
        else
            mcus_x_in = MCU_W'(w_round >> 4);
        if (img_height == '0)
            mcus_y_in = MCU_W'(1);
        else if (mode_in == 2'b10)
            mcus_y_in = MCU_W'(h_round >> 4);
        else
            mcus_y_in = MCU_W'(h_round >> 3);
    end

    // Position within the MCU and scan.
    logic [1:0]  y_last_blk;
    logic        last_y, mcu_end, last_col, last_mcu, restart_hit;
    logic [15:0] rst_cnt_inc;

    always_comb begin
        case (mode_q)
            2'b01:   y_last_blk = 2'd1;
            2'b10:   y_last_blk = 2'd3;
            default: y_last_blk = 2'd0;
        endcase
        last_y      = (comp_id == 2'd0) && (blk_in_comp == y_last_blk);
        mcu_end     = (NUM_COMP == 1) ? last_y : (comp_id == 2'd2);
        last_col    = (mcu_x == mcus_x_q - MCU_W'(1));
        last_mcu    = last_col && (mcu_y == mcus_y_q - MCU_W'(1));
        rst_cnt_inc = rst_cnt + 16'd1;
        restart_hit = (ri_q != 16'd0) && (rst_cnt_inc == ri_q);
    end

    always_comb begin
        state_n         = state;
        dc_pred_reset_n = 1'b0;
        restart_req_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_scan) begin
                    state_n         = S_DECODE;
                    dc_pred_reset_n = 1'b1;
                end
            end
            S_DECODE: begin
                if (blk_valid)
                    state_n = S_PROCESS;
            end
            S_PROCESS: begin
                if (blk_consumed) begin
                    if (!mcu_end) begin
                        state_n = S_DECODE;
                    end else if (last_mcu) begin
                        state_n = S_DONE;
                    end else if (restart_hit) begin
                        state_n       = S_RESTART;
                        restart_req_n = 1'b1;
                    end else begin
                        state_n = S_DECODE;
                    end
                end
            end
            S_RESTART: begin
                if (restart_ack) begin
                    state_n         = S_DECODE;
                    dc_pred_reset_n = 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (abort) begin
            state_n         = S_IDLE;
            dc_pred_reset_n = 1'b0;
            restart_req_n   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            mode_q        <= 2'b00;
            mcus_x_q      <= '0;
            mcus_y_q      <= '0;
            ri_q          <= '0;
            rst_cnt       <= '0;
            comp_id       <= '0;
            blk_in_comp   <= '0;
            mcu_x         <= '0;
            mcu_y         <= '0;
            dc_pred_reset <= 1'b0;
            restart_req   <= 1'b0;
        end else begin
            state         <= state_n;
            dc_pred_reset <= dc_pred_reset_n;
            restart_req   <= restart_req_n;
            if (abort) begin
                rst_cnt     <= '0;
                comp_id     <= '0;
                blk_in_comp <= '0;
                mcu_x       <= '0;
                mcu_y       <= '0;
            end else if (state == S_IDLE && start_scan) begin
                mode_q      <= mode_in;
                mcus_x_q    <= mcus_x_in;
                mcus_y_q    <= mcus_y_in;
                ri_q        <= restart_interval;
                rst_cnt     <= '0;
                comp_id     <= '0;
                blk_in_comp <= '0;
                mcu_x       <= '0;
                mcu_y       <= '0;
            end else if (state == S_PROCESS && blk_consumed) begin
                if (!mcu_end) begin
                    if (comp_id == 2'd0 && !last_y) begin
                        blk_in_comp <= blk_in_comp + 2'd1;
                    end else begin
                        comp_id     <= comp_id + 2'd1;
                        blk_in_comp <= '0;
                    end
                end else if (!last_mcu) begin
                    // Final MCU leaves the counters on the last block for observation.
                    comp_id     <= '0;
                    blk_in_comp <= '0;
                    rst_cnt     <= rst_cnt_inc;
                    if (last_col) begin
                        mcu_x <= '0;
                        mcu_y <= mcu_y + MCU_W'(1);
                    end else begin
                        mcu_x <= mcu_x + MCU_W'(1);
                    end
                end
            end else if (state == S_RESTART && restart_ack) begin
                rst_cnt <= '0;
            end
        end
    end

    assign bit_ready = (state == S_DECODE) && (huff_enable || entropy_reading);
    assign busy      = (state != S_IDLE);
    assign scan_done = (state == S_DONE);

endmodule

// File: tb/tb_jpeg_mcu_scheduler.sv
// tb/tb_jpeg_mcu_scheduler.sv - scoreboard bench for jpeg_mcu_scheduler (grayscale and colour instances)
module tb_jpeg_mcu_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_scan, sel;
    logic [15:0] img_width, img_height, restart_interval;
    logic [1:0]  subsample_mode;
    logic        huff_enable, entropy_reading, blk_valid, blk_consumed, restart_ack, abort;

    logic        g_bit_ready, g_dc, g_rr, g_done, g_busy;
    logic [1:0]  g_comp, g_blk;
    logic [11:0] g_x, g_y;
    logic        c_bit_ready, c_dc, c_rr, c_done, c_busy;
    logic [1:0]  c_comp, c_blk;
    logic [11:0] c_x, c_y;

    wire start_g = start_scan & ~sel;
    wire start_c = start_scan & sel;

    jpeg_mcu_scheduler #(.NUM_COMP(1), .DIM_W(16), .MCU_W(12)) dut_gray (
        .clk(clk), .rst(rst), .start_scan(start_g),
        .img_width(img_width), .img_height(img_height),
        .subsample_mode(subsample_mode), .restart_interval(restart_interval),
        .huff_enable(huff_enable), .entropy_reading(entropy_reading),
        .blk_valid(blk_valid), .blk_consumed(blk_consumed),
        .restart_ack(restart_ack), .abort(abort),
        .bit_ready(g_bit_ready), .comp_id(g_comp), .blk_in_comp(g_blk),
        .mcu_x(g_x), .mcu_y(g_y), .dc_pred_reset(g_dc), .restart_req(g_rr),
        .scan_done(g_done), .busy(g_busy)
    );

    jpeg_mcu_scheduler #(.NUM_COMP(3), .DIM_W(16), .MCU_W(12)) dut_color (
        .clk(clk), .rst(rst), .start_scan(start_c),
        .img_width(img_width), .img_height(img_height),
        .subsample_mode(subsample_mode), .restart_interval(restart_interval),
        .huff_enable(huff_enable), .entropy_reading(entropy_reading),
        .blk_valid(blk_valid), .blk_consumed(blk_consumed),
        .restart_ack(restart_ack), .abort(abort),
        .bit_ready(c_bit_ready), .comp_id(c_comp), .blk_in_comp(c_blk),
        .mcu_x(c_x), .mcu_y(c_y), .dc_pred_reset(c_dc), .restart_req(c_rr),
        .scan_done(c_done), .busy(c_busy)
    );

    wire        o_bit_ready = sel ? c_bit_ready : g_bit_ready;
    wire        o_dc        = sel ? c_dc   : g_dc;
    wire        o_rr        = sel ? c_rr   : g_rr;
    wire        o_done      = sel ? c_done : g_done;
    wire        o_busy      = sel ? c_busy : g_busy;
    wire [27:0] o_pos       = sel ? {c_comp, c_blk, c_x, c_y} : {g_comp, g_blk, g_x, g_y};
    wire [32:0] o_all_g     = {g_bit_ready, g_dc, g_rr, g_done, g_busy, g_comp, g_blk, g_x, g_y};
    wire [32:0] o_all_c     = {c_bit_ready, c_dc, c_rr, c_done, c_busy, c_comp, c_blk, c_x, c_y};

    typedef struct {
        logic [27:0] pos;
        bit          rr;
        bit          last;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic build_model(input int ncomp, input int mode, input int w, input int h, input int ri);
        int m, mw, mh, nx, ny, yb, cnt;
        bit fin, rr;
        exp_t e;
        m   = (ncomp == 1 || mode == 3) ? 0 : mode;
        mw  = (m == 0) ? 8 : 16;
        mh  = (m == 2) ? 16 : 8;
        nx  = (w == 0) ? 1 : (w + mw - 1) / mw;
        ny  = (h == 0) ? 1 : (h + mh - 1) / mh;
        yb  = (m == 0) ? 1 : (m == 1) ? 2 : 4;
        cnt = 0;
        for (int y = 0; y < ny; y++) begin
            for (int x = 0; x < nx; x++) begin
                fin = (x == nx - 1) && (y == ny - 1);
                rr  = 1'b0;
                if (!fin) begin
                    cnt++;
                    if (ri != 0 && cnt == ri) begin
                        rr  = 1'b1;
                        cnt = 0;
                    end
                end
                for (int b = 0; b < yb; b++) begin
                    e.pos  = {2'd0, 2'(b), 12'(x), 12'(y)};
                    e.rr   = (ncomp == 1 && b == yb - 1) ? rr : 1'b0;
                    e.last = (ncomp == 1 && b == yb - 1) ? fin : 1'b0;
                    sbq.push_back(e);
                end
                if (ncomp == 3) begin
                    e.pos = {2'd1, 2'd0, 12'(x), 12'(y)}; e.rr = 1'b0; e.last = 1'b0;
                    sbq.push_back(e);
                    e.pos = {2'd2, 2'd0, 12'(x), 12'(y)}; e.rr = rr; e.last = fin;
                    sbq.push_back(e);
                end
            end
        end
    endtask

    task automatic run_scan(input bit s, input int w, input int h, input int mode, input int ri,
                            input int delay, input string nm);
        exp_t e;
        sel = s; img_width = 16'(w); img_height = 16'(h);
        subsample_mode = 2'(mode); restart_interval = 16'(ri);
        build_model(s ? 3 : 1, mode, w, h, ri);
        start_scan = 1'b1;
        @(posedge clk); #1;
        start_scan = 1'b0;
        checks++;
        if ({o_dc, o_busy, o_bit_ready} !== 3'b111) begin
            failures++;
            $display("FAIL %s start: dc/busy/bit_ready=%b expected 111", nm, {o_dc, o_busy, o_bit_ready});
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            blk_valid = 1'b1;
            @(posedge clk); #1;
            blk_valid = 1'b0;
            checks++;
            if ({o_pos, o_bit_ready} !== {e.pos, 1'b0}) begin
                failures++;
                $display("FAIL %s block: pos/bit_ready=%h got, %h expected", nm, {o_pos, o_bit_ready}, {e.pos, 1'b0});
            end
            for (int i = 0; i < delay; i++) begin
                start_scan = (i == 10);
                @(posedge clk); #1;
                start_scan = 1'b0;
                checks++;
                if ({o_pos, o_bit_ready, o_dc, o_busy} !== {e.pos, 3'b001}) begin
                    failures++;
                    $display("FAIL %s stall: pos/bit_ready/dc/busy=%h got, %h expected", nm,
                             {o_pos, o_bit_ready, o_dc, o_busy}, {e.pos, 3'b001});
                end
            end
            blk_consumed = 1'b1;
            @(posedge clk); #1;
            blk_consumed = 1'b0;
            checks++;
            if ({o_rr, o_done} !== {e.rr, e.last}) begin
                failures++;
                $display("FAIL %s consume: restart_req/scan_done=%b%b expected %b%b", nm, o_rr, o_done, e.rr, e.last);
            end
            if (e.rr) begin
                repeat (3) begin
                    @(posedge clk); #1;
                    checks++;
                    if ({o_bit_ready, o_busy, o_rr} !== 3'b010) begin
                        failures++;
                        $display("FAIL %s restart_wait: bit_ready/busy/rr=%b expected 010", nm, {o_bit_ready, o_busy, o_rr});
                    end
                end
                restart_ack = 1'b1;
                @(posedge clk); #1;
                restart_ack = 1'b0;
                checks++;
                if ({o_dc, o_bit_ready} !== 2'b11) begin
                    failures++;
                    $display("FAIL %s restart_ack: dc/bit_ready=%b expected 11", nm, {o_dc, o_bit_ready});
                end
            end
            if (e.last) begin
                @(posedge clk); #1;
                checks++;
                if ({o_busy, o_done} !== 2'b00) begin
                    failures++;
                    $display("FAIL %s idle_after_done: busy/scan_done=%b expected 00", nm, {o_busy, o_done});
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_all_g, o_all_c} !== 66'd0) begin
            failures++;
            $display("FAIL reset_in: outputs=%h expected 0", {o_all_g, o_all_c});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({o_all_g, o_all_c} !== 66'd0) begin
            failures++;
            $display("FAIL reset_after: outputs=%h expected 0", {o_all_g, o_all_c});
        end
    endtask

    task automatic test_grayscale();
        huff_enable = 1'b0; entropy_reading = 1'b1;
        run_scan(1'b0, 16, 8, 0, 0, 0, "grayscale");
        huff_enable = 1'b1; entropy_reading = 1'b0;
    endtask

    task automatic test_420();          run_scan(1'b1, 16, 16, 2, 0, 0, "yuv420");       endtask
    task automatic test_non_multiple(); run_scan(1'b1, 17, 9, 1, 0, 0, "non_multiple");  endtask
    task automatic test_restart();      run_scan(1'b1, 32, 8, 0, 2, 0, "restart");       endtask
    task automatic test_back_pressure();run_scan(1'b1, 16, 8, 1, 0, 50, "back_pressure");endtask
    task automatic test_zero_dim();     run_scan(1'b1, 0, 0, 2, 0, 0, "zero_dim");       endtask
    task automatic test_reserved_mode();run_scan(1'b1, 8, 16, 3, 1, 0, "reserved_mode"); endtask

    task automatic test_abort_reset();
        sel = 1'b1; img_width = 16'd16; img_height = 16'd16;
        subsample_mode = 2'b10; restart_interval = 16'd0;
        start_scan = 1'b1; @(posedge clk); #1; start_scan = 1'b0;
        blk_valid = 1'b1; @(posedge clk); #1; blk_valid = 1'b0;
        blk_consumed = 1'b1; @(posedge clk); #1; blk_consumed = 1'b0;
        blk_valid = 1'b1; @(posedge clk); #1; blk_valid = 1'b0;
        checks++;
        if (o_pos !== {2'd0, 2'd1, 24'd0}) begin
            failures++;
            $display("FAIL abort_setup: pos=%h expected %h", o_pos, {2'd0, 2'd1, 24'd0});
        end
        abort = 1'b1; blk_consumed = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; blk_consumed = 1'b0;
        checks++;
        if (o_all_c !== 33'd0) begin
            failures++;
            $display("FAIL abort: outputs=%h expected 0", o_all_c);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_busy, o_done} !== 2'b00) begin
            failures++;
            $display("FAIL abort_quiet: busy/scan_done=%b expected 00", {o_busy, o_done});
        end
        start_scan = 1'b1; @(posedge clk); #1; start_scan = 1'b0;
        checks++;
        if (o_bit_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_setup: bit_ready=%b expected 1", o_bit_ready);
        end
        rst = 1'b1; abort = 1'b1; start_scan = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({o_all_g, o_all_c} !== 66'd0) begin
            failures++;
            $display("FAIL rst_mid_decode: outputs=%h expected 0", {o_all_g, o_all_c});
        end
        rst = 1'b0; abort = 1'b0; start_scan = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({o_all_g, o_all_c} !== 66'd0) begin
            failures++;
            $display("FAIL rst_release: outputs=%h expected 0", {o_all_g, o_all_c});
        end
        run_scan(1'b1, 8, 8, 0, 0, 0, "after_reset");
    endtask

    initial begin
        rst = 1'b1; start_scan = 1'b0; sel = 1'b1;
        img_width = '0; img_height = '0; subsample_mode = '0; restart_interval = '0;
        huff_enable = 1'b1; entropy_reading = 1'b0;
        blk_valid = 1'b0; blk_consumed = 1'b0; restart_ack = 1'b0; abort = 1'b0;
        test_reset();
        test_grayscale();
        test_420();
        test_non_multiple();
        test_restart();
        test_back_pressure();
        test_zero_dim();
        test_reserved_mode();
        test_abort_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jpeg_mcu_scheduler.md
JPEG_MCU_SCHEDULER -- requirements
Module: jpeg_mcu_scheduler

Interface
REQ-001 SHALL have parameter NUM_COMP, default 3, number of colour components per scan (legal values 1 or 3).
REQ-002 SHALL have parameter DIM_W, default 16, width of the image-dimension inputs.
REQ-003 SHALL have parameter MCU_W, default 12, width of the MCU column/row counters.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port start_scan, input, 1, one-cycle pulse from the header parser (SOS done).
REQ-007 SHALL have ports img_width and img_height, input, DIM_W each, pixel dimensions; sampled on accepted start_scan.
REQ-008 SHALL have port subsample_mode, input, 2, 00=4:4:4, 01=4:2:2, 10=4:2:0, 11=reserved (treated as 00); sampled on start_scan.
REQ-009 SHALL have port restart_interval, input, 16, MCUs between RST markers, 0=disabled; sampled on start_scan.
REQ-010 SHALL have ports huff_enable and entropy_reading, input, 1 each, bit demand from the Huffman and entropy decoders.
REQ-011 SHALL have port blk_valid, input, 1, coefficient accumulator holds a complete 8x8 block.
REQ-012 SHALL have port blk_consumed, input, 1, one-cycle pulse: serializer finished emitting the current block.
REQ-013 SHALL have port restart_ack, input, 1, bitstream reader consumed the RSTn marker.
REQ-014 SHALL have port abort, input, 1, synchronous scan cancel.
REQ-015 SHALL have port bit_ready, output, 1, bitstream-reader shift enable.
REQ-016 SHALL have ports comp_id (2) and blk_in_comp (2), output, current component and block index within that component.
REQ-017 SHALL have ports mcu_x and mcu_y, output, MCU_W each, current MCU column and row.
REQ-018 SHALL have ports dc_pred_reset, restart_req and scan_done, output, 1 each; all are one-cycle pulses.
REQ-019 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-020 SHALL implement states IDLE, DECODE, PROCESS, RESTART and DONE.
REQ-021 SHALL take IDLE->DECODE on start_scan; same edge latches the geometry, zeroes all counters and pulses dc_pred_reset.
REQ-022 SHALL ignore start_scan outside IDLE.
REQ-023 SHALL drive bit_ready = (huff_enable | entropy_reading) when the state is DECODE, and 0 in all other states (combinational).
REQ-024 SHALL take DECODE->PROCESS on the cycle blk_valid=1.
REQ-025 SHALL hold PROCESS until blk_consumed=1, then advance the block sequence (REQ-026) on that edge.
REQ-026 SHALL use the following block sequence per MCU:
 - Y: 1, 2 or 4 blocks for mode 00, 01 or 10 respectively.
 - Then Cb: 1 block; then Cr: 1 block.
 - NUM_COMP=1: Y only, 1 block per MCU, mode ignored.
REQ-027 SHALL use MCU sizes of 8x8 (mode 00 or NUM_COMP=1), 16x8 (mode 01) and 16x16 (mode 10).
REQ-028 SHALL compute mcus_x = ceil(img_width/mcu_w) and mcus_y = ceil(img_height/mcu_h), using shifts and add-round only.
REQ-029 SHALL handle the end of an MCU as follows:
 - mcu_x wraps to 0 at mcus_x-1 and mcu_y increments.
 - The restart counter increments.
REQ-030 SHALL go from PROCESS to DONE after the last block of MCU (mcus_x-1, mcus_y-1); DONE pulses scan_done, then goes to IDLE next cycle.
REQ-031 SHALL enter RESTART on a non-final MCU completion where restart_interval≠0 and the counter reaches restart_interval; entry pulses restart_req, otherwise PROCESS->DECODE.
REQ-032 SHALL, in RESTART, wait for restart_ack; on ack it zeroes the restart counter, pulses dc_pred_reset and goes to DECODE.
REQ-033 SHALL never enter RESTART at the final MCU; DONE takes priority.
REQ-034 SHALL treat img_width=0 or img_height=0 as 1 MCU.
REQ-035 SHALL give abort priority over every other event; it forces IDLE and counter reset on the next edge, with no scan_done.
REQ-036 SHALL ignore blk_valid outside DECODE and blk_consumed outside PROCESS.

Reset
REQ-037 SHALL, on rst=1 at a clock edge, force the state to IDLE and clear all counters and latched geometry.
REQ-038 SHALL hold every output at 0 while in reset and immediately after (busy=0, bit_ready=0).
REQ-039 SHALL give rst priority over abort and start_scan, including mid-block.

Verification
REQ-040 SHALL cover grayscale: NUM_COMP=1, 16x8, mode 00 -> 2 blocks, mcu_x 0,1, scan_done after the 2nd blk_consumed, no restart_req.
REQ-041 SHALL cover 4:2:0: 16x16, NUM_COMP=3 -> comp_id sequence 0,0,0,0,1,2 with blk_in_comp 0,1,2,3,0,0, then scan_done.
REQ-042 SHALL cover non-multiple size: 17x9, mode 01 -> mcus_x=2, mcus_y=2, 16 blocks total.
REQ-043 SHALL cover restart: 32x8, mode 00, restart_interval=2 -> restart_req after MCU 1 only, bit_ready=0 until restart_ack, dc_pred_reset on ack, no restart before scan_done.
REQ-044 SHALL cover back-pressure: blk_consumed delayed 50 cycles -> bit_ready=0 throughout PROCESS with huff_enable=1; counters stable.
REQ-045 SHALL cover abort and reset: abort in PROCESS -> IDLE next cycle, busy=0, no scan_done; rst mid-DECODE -> all outputs 0; a following start_scan is accepted.
